bpu_update_sched: RTL
=====================

BPU_UPDATE_SCHED -- requirements
Module: bpu_update_sched

Interface
REQ-001 The module SHALL have parameter NRET, default 4, meaning number of commit slots that may present branch updates per cycle.
REQ-002 The module SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-003 The module SHALL have parameter DEPTH, default 8, meaning queue entries; it must be a power of two and at least NRET.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port cmt_valid_i, input, NRET bits: per-slot update request.
REQ-007 The module SHALL have port cmt_pc_i, input, NRET x XLEN bits: branch PC per slot.
REQ-008 The module SHALL have port cmt_target_i, input, NRET x XLEN bits: resolved target per slot.
REQ-009 The module SHALL have ports cmt_is_cond_i, cmt_taken_i, cmt_is_call_i and cmt_is_ret_i, input, NRET bits each: per-slot branch attributes.
REQ-010 The module SHALL have port cmt_ready_o, output, 1 bit: the queue can accept a full NRET-wide group this cycle.
REQ-011 The module SHALL have port bpu_hold_i, input, 1 bit: the BPU update port must not consume this cycle.
REQ-012 The module SHALL have ports update_valid_o, update_pc_o, update_target_o, update_is_cond_o, update_taken_o, update_is_call_o and update_is_ret_o, output, widths 1/XLEN/XLEN/1/1/1/1: single-port BPU update.
REQ-013 The module SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-014 The module SHALL have port drop_o, output, 1 bit: pulse, a request was presented while cmt_ready_o=0.

Function
REQ-015 The queue SHALL be a circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
REQ-016 cmt_ready_o SHALL be combinational and equal (DEPTH - count) >= NRET, based on the registered count only.
REQ-017 When cmt_ready_o=1, every slot with cmt_valid_i set SHALL be enqueued in one cycle, compacted in ascending slot order starting at tail; tail advances by popcount(cmt_valid_i).
REQ-018 When cmt_ready_o=0 and any cmt_valid_i bit is set, nothing SHALL be enqueued, drop_o SHALL be 1 for that cycle, and the queue state stays unchanged except for a pop.
REQ-019 The output SHALL be first-word-fall-through from the head entry: update_valid_o = (count != 0) and not bpu_hold_i; payload outputs reflect the head entry whenever count != 0, and 0 otherwise.
REQ-020 A pop SHALL occur when update_valid_o=1; head advances by 1.
REQ-021 Latency SHALL be exactly one cycle: an entry enqueued at edge N is visible on update_* after edge N if it is at head; there is no same-cycle bypass.
REQ-022 On a simultaneous push and pop, the next count SHALL be count + popcount - 1, and a full queue with a pop still does not accept (REQ-016).
REQ-023 Order SHALL be preserved: entries leave in commit order (older cycle first, lower slot first within a cycle).
REQ-024 Branch updates are architectural; there is no flush input, and no entry SHALL ever be discarded once accepted.
REQ-025 count SHALL never exceed DEPTH or underflow.

Reset
REQ-026 While rst_i=1 at a rising edge, head, tail and count SHALL be cleared to 0 and all queue contents become invalid.
REQ-027 After reset, outputs SHALL be: update_valid_o=0, all update payload outputs 0, count_o=0, cmt_ready_o=1, drop_o=0.
REQ-028 Reset SHALL take priority over a simultaneous push or pop; requests presented in a reset cycle are not enqueued and do not raise drop_o.

Verification
REQ-029 Single push: cmt_valid_i=4'b0100, pc[2]=0x80000010, taken=1 -> next cycle update_valid_o=1, update_pc_o=0x80000010, update_taken_o=1; the following cycle count_o=0.
REQ-030 Compaction/order: cmt_valid_i=4'b1011 with pcs 0x100/0x104/0x108/0x10C -> update_pc_o sequence 0x100, 0x104, 0x10C on three consecutive cycles.
REQ-031 Backpressure: bpu_hold_i=1 and 5 entries queued -> cmt_ready_o=0; a push of 4'b0001 raises drop_o=1 and count_o stays at 5.
REQ-032 Wrap-around: 3 groups of 4 entries interleaved with drain, with head passing index 7 -> 0 -> output order matches input order and no entry is lost or duplicated.
REQ-033 Simultaneous push+pop at count=4: push 4'b1111 with hold=0 -> next count_o=7.
REQ-034 Reset mid-operation: rst_i=1 with count_o=6 and cmt_valid_i=4'b1111 -> next cycle count_o=0, update_valid_o=0, drop_o=0.

Source files
------------

// File: rtl/bpu_update_sched.sv
// Branch-predictor update scheduler: collects up to NRET committed branch updates per
// cycle into a small in-order queue and drains them one per cycle into a single BPU port.
module bpu_update_sched #(
  parameter int NRET  = 4,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NRET-1:0]            cmt_valid_i,
  input  logic [NRET-1:0][XLEN-1:0]  cmt_pc_i,
  input  logic [NRET-1:0][XLEN-1:0]  cmt_target_i,
  input  logic [NRET-1:0]            cmt_is_cond_i,
  input  logic [NRET-1:0]            cmt_taken_i,
  input  logic [NRET-1:0]            cmt_is_call_i,
  input  logic [NRET-1:0]            cmt_is_ret_i,
  output logic                       cmt_ready_o,
  input  logic                       bpu_hold_i,
  output logic                       update_valid_o,
  output logic [XLEN-1:0]            update_pc_o,
  output logic [XLEN-1:0]            update_target_o,
  output logic                       update_is_cond_o,
  output logic                       update_taken_o,
  output logic                       update_is_call_o,
  output logic                       update_is_ret_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] tgt_mem  [DEPTH];
  logic [3:0]      attr_mem [DEPTH];

  logic [CNT_W-1:0] slot_off [NRET];
  logic [PTR_W-1:0] wr_idx   [NRET];
  logic [CNT_W-1:0] push_cnt;
  logic             any_req;
  logic             push;
  logic             pop;
  logic             nonempty;

  // Compaction: each valid slot lands at tail + number of valid lower slots.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NRET; i++) begin
      slot_off[i] = push_cnt;
      wr_idx[i]   = tail_q + push_cnt[PTR_W-1:0];
      push_cnt    = push_cnt + CNT_W'(cmt_valid_i[i]);
    end
  end

  assign any_req     = |cmt_valid_i;
  assign cmt_ready_o = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NRET);
  assign push        = cmt_ready_o & any_req;
  assign nonempty    = (count_q != '0);
  assign pop         = update_valid_o;
  assign drop_o      = any_req & ~cmt_ready_o & ~rst_i;

  assign update_valid_o   = nonempty & ~bpu_hold_i;
  assign update_pc_o      = nonempty ? pc_mem[head_q]      : '0;
  assign update_target_o  = nonempty ? tgt_mem[head_q]     : '0;
  assign update_is_cond_o = nonempty ? attr_mem[head_q][3] : 1'b0;
  assign update_taken_o   = nonempty ? attr_mem[head_q][2] : 1'b0;
  assign update_is_call_o = nonempty ? attr_mem[head_q][1] : 1'b0;
  assign update_is_ret_o  = nonempty ? attr_mem[head_q][0] : 1'b0;
  assign count_o          = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + push_cnt[PTR_W-1:0];
    end
    count_d = count_q + (push ? push_cnt : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int i = 0; i < NRET; i++) begin
        if (cmt_valid_i[i]) begin
          pc_mem[wr_idx[i]]   <= cmt_pc_i[i];
          tgt_mem[wr_idx[i]]  <= cmt_target_i[i];
          attr_mem[wr_idx[i]] <= {cmt_is_cond_i[i], cmt_taken_i[i],
                                  cmt_is_call_i[i], cmt_is_ret_i[i]};
        end
      end
    end
  end

endmodule
